// File: rtl/can_tx_bitstream.sv
// -----------------------------------------------------------------------------
// can_tx_bitstream
//
// Transmit-side bit-stream engine of the CAN controller. Frame bits arrive one
// at a time from the frame sequencer through a single-entry holding register.
// Stuff bits are inserted automatically inside the stuffed region. The line is
// updated at each tx_point strobe from the bit timing block. At each
// sample_point the sampled bus value is compared with the driven bit, and bit
// errors or arbitration loss are flagged.
//
// Parameters
//   STUFF_LEN     number of identical consecutive bits that forces a
//                 complementary stuff bit (2..7)
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   tx_point      strobe: start of a new bit time (line update)
//   sample_point  strobe: bus sampled, sampled_bit valid
//   sampled_bit   bus value captured at sample_point
//   bit_valid     sequencer offers a frame bit
//   bit_data      frame bit value (0 = dominant)
//   bit_stuff_en  frame bit lies in the stuffed region
//   bit_kind      00 normal, 01 arbitration, 10 ACK slot, 11 treated as 00
//   bit_ready     holding register empty; handshake is bit_valid & bit_ready
//   abort         flush everything, line back to recessive
//   tx            line drive
//   tx_next       value that will be driven at the next tx_point
//   transmitting  a frame bit or stuff bit is on the line
//   stuff_active  the bit on the line is a stuff bit
//   bit_err       one-cycle pulse: driven/received mismatch
//   arb_lost      one-cycle pulse: recessive sent, dominant read, arbitration
// -----------------------------------------------------------------------------
module can_tx_bitstream #(
  parameter int STUFF_LEN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_point,
  input  logic       sample_point,
  input  logic       sampled_bit,
  input  logic       bit_valid,
  input  logic       bit_data,
  input  logic       bit_stuff_en,
  input  logic [1:0] bit_kind,
  output logic       bit_ready,
  input  logic       abort,
  output logic       tx,
  output logic       tx_next,
  output logic       transmitting,
  output logic       stuff_active,
  output logic       bit_err,
  output logic       arb_lost
);

  localparam logic [1:0] KIND_NORMAL = 2'b00;
  localparam logic [1:0] KIND_ARB    = 2'b01;
  localparam logic [1:0] KIND_ACK    = 2'b10;
  localparam logic [1:0] KIND_RSVD   = 2'b11;
  localparam logic [2:0] STUFF_LEN_C = 3'(STUFF_LEN);

  // Holding register
  logic       hold_valid_r;
  logic       hold_bit_r;
  logic       hold_stuff_en_r;
  logic [1:0] hold_kind_r;

  // Line and stuffing state
  logic       tx_r;
  logic       transmitting_r;
  logic       stuff_active_r;
  logic [1:0] line_kind_r;
  logic [2:0] same_cnt_r;
  logic       last_bit_r;
  logic       pending_stuff_r;
  logic       bit_err_r;
  logic       arb_lost_r;

  // Combinational helpers
  logic       tx_next_s;
  logic [2:0] same_next_s;
  logic       arb_hit_s;
  logic       err_hit_s;

  assign bit_ready    = ~hold_valid_r;
  assign tx           = tx_r;
  assign tx_next      = tx_next_s;
  assign transmitting = transmitting_r;
  assign stuff_active = stuff_active_r;
  assign bit_err      = bit_err_r;
  assign arb_lost     = arb_lost_r;

  // Upcoming line value: a pending stuff bit wins over the held frame bit
  always_comb begin
    tx_next_s = 1'b1;
    if (pending_stuff_r) begin
      tx_next_s = ~last_bit_r;
    end else if (hold_valid_r) begin
      tx_next_s = hold_bit_r;
    end else begin
      tx_next_s = 1'b1;
    end
  end

  // Run length after the held bit goes out (restarts at 1 on a level change)
  always_comb begin
    same_next_s = 3'd1;
    if (hold_bit_r == last_bit_r) begin
      same_next_s = same_cnt_r + 3'd1;
    end else begin
      same_next_s = 3'd1;
    end
  end

  // Bus compare against the bit currently on the line (pre-update tx)
  always_comb begin
    arb_hit_s = 1'b0;
    err_hit_s = 1'b0;
    if (sample_point && transmitting_r && (sampled_bit != tx_r)) begin
      if (!stuff_active_r && (line_kind_r == KIND_ACK)) begin
        // ACK slot: the receivers overwrite our recessive bit, not an error
        arb_hit_s = 1'b0;
        err_hit_s = 1'b0;
      end else if (!stuff_active_r && (line_kind_r == KIND_ARB) &&
                   tx_r && !sampled_bit) begin
        arb_hit_s = 1'b1;
        err_hit_s = 1'b0;
      end else begin
        arb_hit_s = 1'b0;
        err_hit_s = 1'b1;
      end
    end else begin
      arb_hit_s = 1'b0;
      err_hit_s = 1'b0;
    end
  end

  // Holding register, line drive, stuffing state and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_r    <= 1'b0;
      hold_bit_r      <= 1'b1;
      hold_stuff_en_r <= 1'b0;
      hold_kind_r     <= KIND_NORMAL;
      tx_r            <= 1'b1;
      transmitting_r  <= 1'b0;
      stuff_active_r  <= 1'b0;
      line_kind_r     <= KIND_NORMAL;
      same_cnt_r      <= 3'd0;
      last_bit_r      <= 1'b1;
      pending_stuff_r <= 1'b0;
      bit_err_r       <= 1'b0;
      arb_lost_r      <= 1'b0;
    end else if (abort || arb_hit_s || err_hit_s) begin
      // Flush: abort wins and stays silent; an offer made in this cycle
      // belongs to the dead frame and is dropped as well.
      hold_valid_r    <= 1'b0;
      tx_r            <= 1'b1;
      transmitting_r  <= 1'b0;
      stuff_active_r  <= 1'b0;
      line_kind_r     <= KIND_NORMAL;
      same_cnt_r      <= 3'd0;
      last_bit_r      <= 1'b1;
      pending_stuff_r <= 1'b0;
      bit_err_r       <= err_hit_s & ~abort;
      arb_lost_r      <= arb_hit_s & ~abort;
    end else begin
      bit_err_r  <= 1'b0;
      arb_lost_r <= 1'b0;

      // Load only into an empty holding register; since hold_valid_r is
      // still 0 in the load cycle, a same-cycle tx_point cannot consume it.
      if (bit_valid && !hold_valid_r) begin
        hold_valid_r    <= 1'b1;
        hold_bit_r      <= bit_data;
        hold_stuff_en_r <= bit_stuff_en;
        hold_kind_r     <= (bit_kind == KIND_RSVD) ? KIND_NORMAL : bit_kind;
      end else begin
        hold_valid_r    <= hold_valid_r;
      end

      if (tx_point) begin
        if (pending_stuff_r) begin
          // Stuff bit: the held frame bit waits for the next bit time
          tx_r            <= ~last_bit_r;
          transmitting_r  <= 1'b1;
          stuff_active_r  <= 1'b1;
          line_kind_r     <= KIND_NORMAL;
          same_cnt_r      <= 3'd1;
          last_bit_r      <= ~last_bit_r;
          pending_stuff_r <= 1'b0;
        end else if (hold_valid_r) begin
          tx_r           <= hold_bit_r;
          transmitting_r <= 1'b1;
          stuff_active_r <= 1'b0;
          line_kind_r    <= hold_kind_r;
          last_bit_r     <= hold_bit_r;
          hold_valid_r   <= 1'b0;
          if (hold_stuff_en_r) begin
            same_cnt_r      <= same_next_s;
            pending_stuff_r <= (same_next_s == STUFF_LEN_C);
          end else begin
            same_cnt_r      <= 3'd0;
            pending_stuff_r <= 1'b0;
          end
        end else begin
          tx_r            <= 1'b1;
          transmitting_r  <= 1'b0;
          stuff_active_r  <= 1'b0;
          line_kind_r     <= KIND_NORMAL;
          same_cnt_r      <= 3'd0;
          last_bit_r      <= 1'b1;
          pending_stuff_r <= 1'b0;
        end
      end else begin
        tx_r            <= tx_r;
        pending_stuff_r <= pending_stuff_r;
      end
    end
  end

endmodule

// File: tb/tb_can_tx_bitstream.sv
// -----------------------------------------------------------------------------
// tb_can_tx_bitstream
//
// Directed and randomized bench for can_tx_bitstream. A simple timing block
// (tx_point every 4 cycles, sample_point 2 cycles later) and a sequencer are
// driven from one initial block. Expected line sequences come from a list
// transform of each frame: after every STUFF_LEN identical bits of the stuffed
// stream, the complement is appended.
// -----------------------------------------------------------------------------
module tb_can_tx_bitstream;

  localparam int STUFF_LEN = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_point;
  logic       sample_point;
  logic       sampled_bit;
  logic       bit_valid;
  logic       bit_data;
  logic       bit_stuff_en;
  logic [1:0] bit_kind;
  logic       bit_ready;
  logic       abort;
  logic       tx;
  logic       tx_next;
  logic       transmitting;
  logic       stuff_active;
  logic       bit_err;
  logic       arb_lost;

  always #5 clk = ~clk;

  can_tx_bitstream #(.STUFF_LEN(STUFF_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_point     (tx_point),
    .sample_point (sample_point),
    .sampled_bit  (sampled_bit),
    .bit_valid    (bit_valid),
    .bit_data     (bit_data),
    .bit_stuff_en (bit_stuff_en),
    .bit_kind     (bit_kind),
    .bit_ready    (bit_ready),
    .abort        (abort),
    .tx           (tx),
    .tx_next      (tx_next),
    .transmitting (transmitting),
    .stuff_active (stuff_active),
    .bit_err      (bit_err),
    .arb_lost     (arb_lost)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic       frame_bit_q[$];
  logic       frame_se_q[$];
  logic [1:0] frame_kind_q[$];
  logic       exp_val_q[$];
  logic       exp_stuff_q[$];
  logic       obs_val_q[$];
  logic       obs_stuff_q[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    frame_bit_q.delete();
    frame_se_q.delete();
    frame_kind_q.delete();
  endtask

  task automatic add_bit(input logic b, input logic se, input logic [1:0] k);
    frame_bit_q.push_back(b);
    frame_se_q.push_back(se);
    frame_kind_q.push_back(k);
  endtask

  // Expected line: every frame bit, plus a complement after each run of
  // STUFF_LEN identical bits in the stuffed stream (stuff bits count).
  function automatic void build_expected();
    logic last;
    int   run;
    exp_val_q.delete();
    exp_stuff_q.delete();
    last = 1'b1;
    run  = 0;
    foreach (frame_bit_q[i]) begin
      exp_val_q.push_back(frame_bit_q[i]);
      exp_stuff_q.push_back(1'b0);
      if (frame_se_q[i]) begin
        run  = (frame_bit_q[i] == last) ? run + 1 : 1;
        last = frame_bit_q[i];
        if (run == STUFF_LEN) begin
          exp_val_q.push_back(~last);
          exp_stuff_q.push_back(1'b1);
          last = ~last;
          run  = 1;
        end
      end else begin
        run  = 0;
        last = frame_bit_q[i];
      end
    end
  endfunction

  // Send the queued frame with echo sampling, then two idle bit times.
  task automatic run_frame(input string tag);
    int n, nb, fi, li, consumed, cycles;
    build_expected();
    obs_val_q.delete();
    obs_stuff_q.delete();
    n        = exp_val_q.size();
    nb       = frame_bit_q.size();
    fi       = 0;
    li       = 0;
    consumed = 0;
    cycles   = (n + 2) * 4 + 1;
    for (int c = 0; c < cycles; c++) begin
      logic accept, is_tx, is_samp, exp_v, exp_s, exp_t;
      is_tx   = ((c % 4) == 2);
      is_samp = ((c % 4) == 0) && (c > 0);
      bit_valid = (fi < nb);
      if (fi < nb) begin
        bit_data     = frame_bit_q[fi];
        bit_stuff_en = frame_se_q[fi];
        bit_kind     = frame_kind_q[fi];
      end
      accept       = bit_valid && bit_ready;
      tx_point     = is_tx;
      sample_point = is_samp;
      sampled_bit  = tx;
      if (li < n) begin
        exp_v = exp_val_q[li];
        exp_s = exp_stuff_q[li];
        exp_t = 1'b1;
      end else begin
        exp_v = 1'b1;
        exp_s = 1'b0;
        exp_t = 1'b0;
      end
      if (is_tx) chk({tag, " tx_next"}, tx_next, exp_v);
      tick();
      tx_point     = 1'b0;
      sample_point = 1'b0;
      bit_valid    = 1'b0;
      if (accept) fi++;
      if (is_tx) begin
        chk({tag, " tx"}, tx, exp_v);
        chk({tag, " stuff_active"}, stuff_active, exp_s);
        chk({tag, " transmitting"}, transmitting, exp_t);
        obs_val_q.push_back(tx);
        obs_stuff_q.push_back(stuff_active);
        if (li < n) begin
          if (!exp_s) consumed++;
          li++;
        end
        chk({tag, " bit_ready"}, bit_ready, (fi == consumed));
      end
      if (is_samp) begin
        chk({tag, " no bit_err"}, bit_err, 1'b0);
        chk({tag, " no arb_lost"}, arb_lost, 1'b0);
      end
    end
  endtask

  task automatic chk_obs(input string tag, input int idx, input logic v, input logic s);
    chk({tag, " line value"}, obs_val_q[idx], v);
    chk({tag, " line stuff"}, obs_stuff_q[idx], s);
  endtask

  // One bit on an idle line, sampled with a forced bus value.
  task automatic err_case(input string tag, input logic b, input logic [1:0] k,
                          input logic samp, input logic exp_arb, input logic exp_err);
    logic flush;
    flush        = exp_arb | exp_err;
    bit_valid    = 1'b1;
    bit_data     = b;
    bit_stuff_en = 1'b0;
    bit_kind     = k;
    tick();
    bit_valid = 1'b0;
    chk({tag, " loaded"}, bit_ready, 1'b0);
    tick();
    tx_point = 1'b1;
    tick();
    tx_point = 1'b0;
    chk({tag, " tx driven"}, tx, b);
    tick();
    sample_point = 1'b1;
    sampled_bit  = samp;
    tick();
    sample_point = 1'b0;
    sampled_bit  = 1'b1;
    chk({tag, " arb_lost"}, arb_lost, exp_arb);
    chk({tag, " bit_err"}, bit_err, exp_err);
    chk({tag, " tx after"}, tx, flush ? 1'b1 : b);
    chk({tag, " transmitting after"}, transmitting, ~flush);
    chk({tag, " bit_ready after"}, bit_ready, 1'b1);
    tick();
    chk({tag, " arb_lost one cycle"}, arb_lost, 1'b0);
    chk({tag, " bit_err one cycle"}, bit_err, 1'b0);
    tx_point = 1'b1;
    tick();
    tx_point = 1'b0;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    tx_point     = 1'b0;
    sample_point = 1'b0;
    sampled_bit  = 1'b1;
    bit_valid    = 1'b0;
    bit_data     = 1'b1;
    bit_stuff_en = 1'b0;
    bit_kind     = 2'b00;
    abort        = 1'b0;
    tick();
    tick();
    chk("reset tx", tx, 1'b1);
    chk("reset tx_next", tx_next, 1'b1);
    chk("reset bit_ready", bit_ready, 1'b1);
    chk("reset transmitting", transmitting, 1'b0);
    chk("reset stuff_active", stuff_active, 1'b0);
    chk("reset bit_err", bit_err, 1'b0);
    chk("reset arb_lost", arb_lost, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();

    // Five dominant bits force a recessive stuff bit before the sixth bit
    clear_frame();
    for (int i = 0; i < 5; i++) add_bit(1'b0, 1'b1, 2'b00);
    add_bit(1'b1, 1'b1, 2'b00);
    run_frame("stuff0");
    chk_obs("stuff0 b4", 4, 1'b0, 1'b0);
    chk_obs("stuff0 s", 5, 1'b1, 1'b1);
    chk_obs("stuff0 b5", 6, 1'b1, 1'b0);

    // Stuff bit after the last stuffed bit even if the next bit is unstuffed
    clear_frame();
    for (int i = 0; i < 5; i++) add_bit(1'b1, 1'b1, 2'b01);
    add_bit(1'b1, 1'b0, 2'b00);
    run_frame("stuff1");
    chk_obs("stuff1 s", 5, 1'b0, 1'b1);
    chk_obs("stuff1 b5", 6, 1'b1, 1'b0);

    // Sampling an idle line never raises a flag
    sample_point = 1'b1;
    sampled_bit  = 1'b0;
    tick();
    sample_point = 1'b0;
    sampled_bit  = 1'b1;
    chk("idle sample bit_err", bit_err, 1'b0);
    chk("idle sample arb_lost", arb_lost, 1'b0);
    tick();

    err_case("arb", 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    err_case("ack", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    err_case("berr", 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    err_case("arb dominant", 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
    err_case("kind11", 1'b1, 2'b11, 1'b0, 1'b0, 1'b1);

    // Abort together with tx_point and a mismatching sample while holding
    // a bit in the middle of a dominant run
    for (int i = 0; i < 3; i++) begin
      bit_valid    = 1'b1;
      bit_data     = 1'b0;
      bit_stuff_en = 1'b1;
      bit_kind     = 2'b00;
      tick();
      bit_valid = 1'b0;
      tick();
      tx_point = 1'b1;
      tick();
      tx_point = 1'b0;
      tick();
    end
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    tick();
    chk("abort pre tx", tx, 1'b0);
    tx_point     = 1'b1;
    sample_point = 1'b1;
    sampled_bit  = 1'b1;
    abort        = 1'b1;
    tick();
    tx_point     = 1'b0;
    sample_point = 1'b0;
    abort        = 1'b0;
    chk("abort tx", tx, 1'b1);
    chk("abort bit_ready", bit_ready, 1'b1);
    chk("abort transmitting", transmitting, 1'b0);
    chk("abort bit_err", bit_err, 1'b0);
    chk("abort arb_lost", arb_lost, 1'b0);
    tick();
    chk("abort tx_next", tx_next, 1'b1);
    clear_frame();
    for (int i = 0; i < 5; i++) add_bit(1'b0, 1'b1, 2'b00);
    run_frame("post abort");
    chk_obs("post abort b4", 4, 1'b0, 1'b0);
    chk_obs("post abort s", 5, 1'b1, 1'b1);

    // Random frames: long runs, random stuffed-region length and kinds
    for (int f = 0; f < 10; f++) begin
      int   nb, ns;
      logic b;
      nb = $urandom_range(30, 8);
      ns = $urandom_range(nb, 4);
      b  = 1'($urandom_range(1, 0));
      clear_frame();
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(3, 0) == 0) b = ~b;
        add_bit(b, (i < ns), 2'($urandom_range(3, 0)));
      end
      run_frame($sformatf("rand%0d", f));
    end

    // Asynchronous reset between clock edges in the middle of a frame
    bit_valid    = 1'b1;
    bit_data     = 1'b0;
    bit_stuff_en = 1'b1;
    bit_kind     = 2'b00;
    tick();
    bit_valid = 1'b0;
    tick();
    tx_point = 1'b1;
    tick();
    tx_point = 1'b0;
    chk("mid frame tx", tx, 1'b0);
    chk("mid frame transmitting", transmitting, 1'b1);
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("mid frame held", bit_ready, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst tx", tx, 1'b1);
    chk("async rst bit_ready", bit_ready, 1'b1);
    chk("async rst transmitting", transmitting, 1'b0);
    chk("async rst stuff_active", stuff_active, 1'b0);
    chk("async rst tx_next", tx_next, 1'b1);
    tick();
    tick();
    chk("rst hold tx", tx, 1'b1);
    chk("rst hold bit_ready", bit_ready, 1'b1);
    chk("rst hold bit_err", bit_err, 1'b0);
    chk("rst hold arb_lost", arb_lost, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/can_tx_bitstream.md
Name: can_tx_bitstream

Overview:
Transmit-side bit-stream engine for the CAN controller, paired with the bit timing block. Accepts frame bits one at a time from the frame sequencer and inserts CAN stuff bits. Drives the TX line at each tx_point and presents the upcoming bit on tx_next for the timing block. At each sample_point it compares the sampled bus value with the driven bit and flags bit errors or arbitration loss.

Parameters:
STUFF_LEN, 5, number of consecutive identical bits after which a complementary stuff bit is inserted (legal range 2..7).

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
tx_point  in  1  single-cycle strobe from the timing block: start of a new bit time
sample_point  in  1  single-cycle strobe from the timing block: bus sampled
sampled_bit  in  1  bus value captured at sample_point
bit_valid  in  1  sequencer offers a frame bit
bit_data  in  1  frame bit value (0 = dominant)
bit_stuff_en  in  1  bit lies in the stuffed region (SOF through CRC)
bit_kind  in  2  00 normal, 01 arbitration field, 10 ACK slot (no compare), 11 reserved (treated as 00)
bit_ready  out  1  holding register empty; bit accepted on bit_valid & bit_ready
abort  in  1  flush immediately and return the line to recessive
tx  out  1  line drive
tx_next  out  1  value that will be driven at the next tx_point
transmitting  out  1  a frame bit or stuff bit is currently on the line
stuff_active  out  1  the bit currently on the line is a stuff bit
bit_err  out  1  one-cycle pulse: transmitted/received mismatch
arb_lost  out  1  one-cycle pulse: recessive sent, dominant read, in the arbitration field

Behaviour:
- Reset values: tx=1, tx_next=1, bit_ready=1, transmitting=0, stuff_active=0, bit_err=0, arb_lost=0. Internal state is cleared: hold_valid=0, same_cnt=0, last_bit=1, pending_stuff=0.
- Holding register: one entry storing bit, stuff_en, and kind. A bit is loaded on bit_valid & bit_ready, and bit_ready drops on the next cycle. The entry is consumed only at a tx_point strictly after the load. A bit accepted in the same cycle as a tx_point waits for the following tx_point.
- tx_next is combinational: pending_stuff ? ~last_bit : (hold_valid ? hold_bit : 1).
- At tx_point, the sources have the following priority:
  1. pending_stuff: tx <= ~last_bit, stuff_active=1, transmitting=1, same_cnt <= 1, last_bit <= ~last_bit, pending_stuff <= 0. The holding entry is not consumed.
  2. hold_valid: tx <= hold_bit, stuff_active=0, transmitting=1, and the entry is consumed (bit_ready=1 on the next cycle).
     - If stuff_en=1: same_cnt <= (hold_bit==last_bit) ? same_cnt+1 : 1, and last_bit <= hold_bit. pending_stuff is set when the new same_cnt equals STUFF_LEN.
     - If stuff_en=0: same_cnt <= 0 and last_bit <= hold_bit.
  3. Neither: tx <= 1, transmitting=0, stuff_active=0, same_cnt <= 0, last_bit <= 1.
- Stuff insertion is decided by the preceding stuffed bit. The stuff bit following the last CRC bit is therefore inserted even when the next held bit has stuff_en=0.
- same_cnt is 3 bits wide and never exceeds STUFF_LEN.
- At sample_point with transmitting=1, sampled_bit is compared with tx:
  - Match, or kind=ACK on a non-stuff bit: no action.
  - Mismatch, kind=arbitration, non-stuff bit, tx=1, sampled_bit=0: pulse arb_lost. This does not pulse bit_err.
  - Any other mismatch, including on a stuff bit: pulse bit_err.
  - On arb_lost or bit_err: the next cycle sets tx=1, transmitting=0, and clears hold_valid, pending_stuff, same_cnt, and last_bit (=1). Bits offered afterwards are accepted normally.
- The kind of the bit on the line is registered at tx_point. A stuff bit has kind normal.
- abort takes priority over tx_point and sample_point in the same cycle. It applies the same flush as an error and produces no pulses.
- tx_point and sample_point both high in one cycle: the compare uses the pre-update tx, then the tx_point update applies.
- No sample_point while transmitting=0 raises any flag.

Test Plan:
- Feed 0,0,0,0,0,1 with stuff_en=1 (STUFF_LEN=5) -> line sequence 0,0,0,0,0,1(stuff_active=1),1. bit_ready stays low during the stuff bit.
- Feed 1×5 stuff_en=1, then one bit with stuff_en=0 -> stuff bit 0 is driven before the sixth bit.
- Send recessive kind=01 and sample 0 -> arb_lost pulses for 1 cycle, bit_err=0, tx=1 and transmitting=0 on the next cycle, bit_ready=1.
- Send 1 with kind=10 and sample 0 -> no flag. Send 0 with kind=00 and sample 1 -> bit_err pulses and the line is flushed.
- Assert abort in the same cycle as tx_point while holding a bit -> tx stays 1, bit_ready=1, no pulses. Then 0,0,0,0,0 restarts counting from same_cnt=0.
- Assert rst_n low mid-frame (asynchronous, between edges) -> tx=1 and bit_ready=1 immediately, and all outputs hold reset values.
